// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, i_Ex control-bit
// positions, CCR bit layout and the operand-forwarding mux.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_PASS1 = 4'd0,
    ALU_NOT   = 4'd1,
    ALU_INC   = 4'd2,
    ALU_DEC   = 4'd3,
    ALU_ADD   = 4'd4,
    ALU_SUB   = 4'd5,
    ALU_AND   = 4'd6,
    ALU_OR    = 4'd7,
    ALU_SHL   = 4'd8,
    ALU_SHR   = 4'd9,
    ALU_SETC  = 4'd10,
    ALU_CLRC  = 4'd11,
    ALU_PASS2 = 4'd12,
    ALU_RSV13 = 4'd13,
    ALU_RSV14 = 4'd14,
    ALU_RSV15 = 4'd15
  } alu_op_e;

  localparam int EX_OP_LSB  = 0;
  localparam int EX_OP_MSB  = 3;
  localparam int EX_IMM_SEL = 4;
  localparam int EX_ST_SEL  = 5;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  typedef logic [2:0] ccr_t;

  // Memory-buffer forwarding takes priority over write-back buffer.
  function automatic logic [15:0] fwd_sel(
    input logic        mem_en,
    input logic [2:0]  mem_rd,
    input logic [15:0] mem_data,
    input logic        wb_en,
    input logic [2:0]  wb_rd,
    input logic [15:0] wb_data,
    input logic [2:0]  rsrc,
    input logic [15:0] rf_data
  );
    if (mem_en && (mem_rd == rsrc)) return mem_data;
    if (wb_en && (wb_rd == rsrc))   return wb_data;
    return rf_data;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 16-bit ALU; returns the result and the full next CCR value
// (bits an opcode does not touch are passed through from flags_i).
module alu_core
  import alu_pkg::*;
(
  input  logic [15:0] op1_i,
  input  logic [15:0] op2_i,
  input  alu_op_e     alu_op_i,
  input  ccr_t        flags_i,
  output logic [15:0] result_o,
  output ccr_t        flags_o
);

  logic [3:0]  sh_amt;
  logic [16:0] shl_w;
  logic [16:0] shr_w;
  logic [16:0] wide;
  logic        carry;
  logic        upd_zn;

  // The extra bit on each shifter catches the last bit shifted out.
  assign sh_amt = op2_i[3:0];
  assign shl_w  = {1'b0, op1_i} << sh_amt;
  assign shr_w  = {op1_i, 1'b0} >> sh_amt;

  always_comb begin
    wide   = {1'b0, op1_i};
    carry  = flags_i[FLAG_C];
    upd_zn = 1'b1;
    case (alu_op_i)
      ALU_NOT: wide = {1'b0, ~op1_i};
      ALU_INC: begin
        wide  = {1'b0, op1_i} + 17'd1;
        carry = wide[16];
      end
      ALU_DEC: begin
        wide  = {1'b0, op1_i} - 17'd1;
        carry = (op1_i == 16'h0000);
      end
      ALU_ADD: begin
        wide  = {1'b0, op1_i} + {1'b0, op2_i};
        carry = wide[16];
      end
      ALU_SUB: begin
        wide  = {1'b0, op1_i} - {1'b0, op2_i};
        carry = (op1_i < op2_i);
      end
      ALU_AND: wide = {1'b0, op1_i & op2_i};
      ALU_OR:  wide = {1'b0, op1_i | op2_i};
      ALU_SHL: begin
        wide = {1'b0, shl_w[15:0]};
        if (sh_amt != 4'd0) carry = shl_w[16];
      end
      ALU_SHR: begin
        wide = {1'b0, shr_w[16:1]};
        if (sh_amt != 4'd0) carry = shr_w[0];
      end
      ALU_SETC: begin
        carry  = 1'b1;
        upd_zn = 1'b0;
      end
      ALU_CLRC: begin
        carry  = 1'b0;
        upd_zn = 1'b0;
      end
      ALU_PASS2: wide = {1'b0, op2_i};
      default:   upd_zn = 1'b0;
    endcase

    result_o        = wide[15:0];
    flags_o         = flags_i;
    flags_o[FLAG_C] = carry;
    if (upd_zn) begin
      flags_o[FLAG_Z] = (wide[15:0] == 16'h0000);
      flags_o[FLAG_N] = wide[15];
    end
  end

endmodule

// File: rtl/alu_stage.sv
// Execute pipeline stage: operand forwarding, ALU, condition-code register
// with interrupt save/restore, and the execute/memory pipeline register.
module alu_stage
  import alu_pkg::*;
#(
  parameter int WbSize  = 2,
  parameter int MemSize = 9,
  parameter int ExSize  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               flush,
  input  logic [WbSize-1:0]  i_WB,
  input  logic [MemSize-1:0] i_Mem,
  input  logic [31:0]        i_pc,
  input  logic [2:0]         i_Rdst,
  input  logic               i_output_write,
  input  logic [ExSize-1:0]  i_Ex,
  input  logic               i_chg_flag,
  input  logic [2:0]         i_Rsrc1,
  input  logic [2:0]         i_Rsrc2,
  input  logic [15:0]        i_read_data1,
  input  logic [15:0]        i_read_data2,
  input  logic [15:0]        i_immd,
  input  logic               i_fw_mem_en,
  input  logic [2:0]         i_fw_mem_rd,
  input  logic [15:0]        i_fw_mem_data,
  input  logic               i_fw_wb_en,
  input  logic [2:0]         i_fw_wb_rd,
  input  logic [15:0]        i_fw_wb_data,
  input  logic               i_flag_save,
  input  logic               i_flag_restore,
  output logic [WbSize-1:0]  o_WB,
  output logic [MemSize-1:0] o_Mem,
  output logic [31:0]        o_pc,
  output logic [2:0]         o_Rdst,
  output logic               o_output_write,
  output logic [15:0]        o_alu_result,
  output logic [15:0]        o_store_data,
  output logic [2:0]         o_flags
);

  logic [15:0] op1, op2_fwd, op2, store_data, alu_result;
  ccr_t        alu_flags;
  alu_op_e     alu_op;
  logic        unused_ex;

  logic [WbSize-1:0]  wb_q, wb_d;
  logic [MemSize-1:0] mem_q, mem_d;
  logic [31:0]        pc_q, pc_d;
  logic [2:0]         rdst_q, rdst_d;
  logic               ow_q, ow_d;
  logic [15:0]        result_q, result_d, store_q, store_d;
  ccr_t               ccr_q, ccr_d, saved_q, saved_d;

  assign op1 = fwd_sel(i_fw_mem_en, i_fw_mem_rd, i_fw_mem_data,
                       i_fw_wb_en, i_fw_wb_rd, i_fw_wb_data, i_Rsrc1, i_read_data1);
  assign op2_fwd = fwd_sel(i_fw_mem_en, i_fw_mem_rd, i_fw_mem_data,
                           i_fw_wb_en, i_fw_wb_rd, i_fw_wb_data, i_Rsrc2, i_read_data2);
  assign op2        = i_Ex[EX_IMM_SEL] ? i_immd : op2_fwd;
  assign store_data = i_Ex[EX_ST_SEL] ? op2_fwd : op1;
  assign alu_op     = alu_op_e'(i_Ex[EX_OP_MSB:EX_OP_LSB]);
  assign unused_ex  = ^i_Ex[ExSize-1:EX_ST_SEL+1];

  alu_core u_alu_core (
    .op1_i    (op1),
    .op2_i    (op2),
    .alu_op_i (alu_op),
    .flags_i  (ccr_q),
    .result_o (alu_result),
    .flags_o  (alu_flags)
  );

  // A bubble still carries pc/result through but cannot write or touch flags.
  always_comb begin
    wb_d     = wb_q;
    mem_d    = mem_q;
    pc_d     = pc_q;
    rdst_d   = rdst_q;
    ow_d     = ow_q;
    result_d = result_q;
    store_d  = store_q;
    ccr_d    = ccr_q;
    saved_d  = saved_q;
    if (enable) begin
      pc_d     = i_pc;
      rdst_d   = i_Rdst;
      result_d = alu_result;
      store_d  = store_data;
      if (flush) begin
        wb_d  = '0;
        mem_d = '0;
        ow_d  = 1'b0;
      end else begin
        wb_d  = i_WB;
        mem_d = i_Mem;
        ow_d  = i_output_write;
        if (i_flag_restore)  ccr_d = saved_q;
        else if (i_chg_flag) ccr_d = alu_flags;
        if (i_flag_save && !i_flag_restore) saved_d = ccr_q;
      end
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      wb_q     <= '0;
      mem_q    <= '0;
      pc_q     <= '0;
      rdst_q   <= '0;
      ow_q     <= 1'b0;
      result_q <= '0;
      store_q  <= '0;
      ccr_q    <= '0;
      saved_q  <= '0;
    end else begin
      wb_q     <= wb_d;
      mem_q    <= mem_d;
      pc_q     <= pc_d;
      rdst_q   <= rdst_d;
      ow_q     <= ow_d;
      result_q <= result_d;
      store_q  <= store_d;
      ccr_q    <= ccr_d;
      saved_q  <= saved_d;
    end
  end

  assign o_WB           = wb_q;
  assign o_Mem          = mem_q;
  assign o_pc           = pc_q;
  assign o_Rdst         = rdst_q;
  assign o_output_write = ow_q;
  assign o_alu_result   = result_q;
  assign o_store_data   = store_q;
  assign o_flags        = ccr_q;

endmodule

// File: tb/tb_alu_stage.sv
// Self-checking bench for alu_stage: vector table through a scoreboard queue,
// then stall, flush and asynchronous-reset sequences.
module tb_alu_stage;
  import alu_pkg::*;

  localparam int WB = 2, MEM = 9, EX = 14;

  logic clk, rst, enable, flush;
  logic [WB-1:0]  i_WB;
  logic [MEM-1:0] i_Mem;
  logic [31:0]    i_pc;
  logic [2:0]     i_Rdst;
  logic           i_output_write;
  logic [EX-1:0]  i_Ex;
  logic           i_chg_flag;
  logic [2:0]     i_Rsrc1, i_Rsrc2;
  logic [15:0]    i_read_data1, i_read_data2, i_immd;
  logic           i_fw_mem_en, i_fw_wb_en;
  logic [2:0]     i_fw_mem_rd, i_fw_wb_rd;
  logic [15:0]    i_fw_mem_data, i_fw_wb_data;
  logic           i_flag_save, i_flag_restore;
  logic [WB-1:0]  o_WB;
  logic [MEM-1:0] o_Mem;
  logic [31:0]    o_pc;
  logic [2:0]     o_Rdst;
  logic           o_output_write;
  logic [15:0]    o_alu_result, o_store_data;
  logic [2:0]     o_flags;

  alu_stage #(.WbSize(WB), .MemSize(MEM), .ExSize(EX)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .i_WB(i_WB), .i_Mem(i_Mem), .i_pc(i_pc), .i_Rdst(i_Rdst),
    .i_output_write(i_output_write), .i_Ex(i_Ex), .i_chg_flag(i_chg_flag),
    .i_Rsrc1(i_Rsrc1), .i_Rsrc2(i_Rsrc2),
    .i_read_data1(i_read_data1), .i_read_data2(i_read_data2), .i_immd(i_immd),
    .i_fw_mem_en(i_fw_mem_en), .i_fw_mem_rd(i_fw_mem_rd), .i_fw_mem_data(i_fw_mem_data),
    .i_fw_wb_en(i_fw_wb_en), .i_fw_wb_rd(i_fw_wb_rd), .i_fw_wb_data(i_fw_wb_data),
    .i_flag_save(i_flag_save), .i_flag_restore(i_flag_restore),
    .o_WB(o_WB), .o_Mem(o_Mem), .o_pc(o_pc), .o_Rdst(o_Rdst),
    .o_output_write(o_output_write), .o_alu_result(o_alu_result),
    .o_store_data(o_store_data), .o_flags(o_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        imm, st;
    logic [2:0]  rs1, rs2;
    logic [15:0] rd1, rd2, immd;
    logic        mem_en;
    logic [2:0]  mem_rd;
    logic [15:0] mem_data;
    logic        wb_en;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        chg, save, rest, cr;
    logic [15:0] e_res, e_st;
    logic [2:0]  e_flags;
  } vec_t;

  typedef struct {
    logic [15:0]    res, st;
    logic [2:0]     flags;
    logic [WB-1:0]  wb;
    logic [MEM-1:0] mem;
    logic [31:0]    pc;
    logic [2:0]     rdst;
    logic           ow;
    logic           cr;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  exp_t last_e, fe;
  vec_t v;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic [3:0] op, input logic [15:0] rd1, rd2, immd,
                              input logic imm, st, chg,
                              input logic [15:0] e_res, e_st, input logic [2:0] e_flags);
    vec_t r;
    r.op = op; r.imm = imm; r.st = st; r.rs1 = 3'd0; r.rs2 = 3'd1;
    r.rd1 = rd1; r.rd2 = rd2; r.immd = immd;
    r.mem_en = 1'b0; r.mem_rd = 3'd6; r.mem_data = 16'hBEEF;
    r.wb_en = 1'b0; r.wb_rd = 3'd7; r.wb_data = 16'hCAFE;
    r.chg = chg; r.save = 1'b0; r.rest = 1'b0; r.cr = 1'b1;
    r.e_res = e_res; r.e_st = e_st; r.e_flags = e_flags;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic drive(input vec_t d, output exp_t e);
    i_Ex = EX'($urandom);
    i_Ex[3:0] = d.op; i_Ex[4] = d.imm; i_Ex[5] = d.st;
    i_Rsrc1 = d.rs1; i_Rsrc2 = d.rs2;
    i_read_data1 = d.rd1; i_read_data2 = d.rd2; i_immd = d.immd;
    i_fw_mem_en = d.mem_en; i_fw_mem_rd = d.mem_rd; i_fw_mem_data = d.mem_data;
    i_fw_wb_en = d.wb_en; i_fw_wb_rd = d.wb_rd; i_fw_wb_data = d.wb_data;
    i_chg_flag = d.chg; i_flag_save = d.save; i_flag_restore = d.rest;
    i_WB = WB'($urandom); i_Mem = MEM'($urandom); i_pc = $urandom;
    i_Rdst = 3'($urandom); i_output_write = 1'($urandom);
    e.res = d.e_res; e.st = d.e_st; e.flags = d.e_flags; e.cr = d.cr;
    e.wb = i_WB; e.mem = i_Mem; e.pc = i_pc; e.rdst = i_Rdst; e.ow = i_output_write;
  endtask

  task automatic check_out(input string tag, input exp_t e);
    if (e.cr) chk({tag, " result"}, 64'(o_alu_result), 64'(e.res));
    chk({tag, " flags"}, 64'(o_flags), 64'(e.flags));
    chk({tag, " store"}, 64'(o_store_data), 64'(e.st));
    chk({tag, " ctrl"}, 64'({o_WB, o_Mem, o_pc, o_Rdst, o_output_write}),
        64'({e.wb, e.mem, e.pc, e.rdst, e.ow}));
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    @(negedge clk); #1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check_out(tag, e);
      last_e = e;
    end
  endtask

  task automatic run_vec(input vec_t d, input string tag);
    exp_t e;
    @(posedge clk);
    drive(d, e);
    sb.push_back(e);
    pop_check(tag);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " outputs"}, 64'({o_WB, o_Mem, o_pc, o_Rdst, o_output_write}), 64'd0);
    chk({tag, " data"}, 64'({o_alu_result, o_store_data, o_flags}), 64'd0);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; flush = 1'b0;
    v = mk(4'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 3'd0);
    drive(v, fe);

    // Flags are {C,N,Z}
    tbl.push_back(mk(4'd4, 16'hFFFF, 16'h0001, 16'h0, 0, 0, 1, 16'h0000, 16'hFFFF, 3'b101));
    v = mk(4'd0, 16'hAAAA, 16'h0, 16'h0, 0, 0, 1, 16'h1234, 16'h1234, 3'b101);
    v.rs1 = 3'd3; v.mem_en = 1; v.mem_rd = 3'd3; v.mem_data = 16'h1234;
    v.wb_en = 1; v.wb_rd = 3'd3; v.wb_data = 16'h5678;
    tbl.push_back(v);
    tbl.push_back(mk(4'd5, 16'h0003, 16'h0005, 16'h0, 0, 1, 0, 16'hFFFE, 16'h0005, 3'b101));
    tbl.push_back(mk(4'd5, 16'h0003, 16'h0005, 16'h0, 0, 0, 1, 16'hFFFE, 16'h0003, 3'b110));
    tbl.push_back(mk(4'd2, 16'h7FFF, 16'h0, 16'h0, 0, 0, 1, 16'h8000, 16'h7FFF, 3'b010));
    tbl.push_back(mk(4'd3, 16'h0000, 16'h0, 16'h0, 0, 0, 1, 16'hFFFF, 16'h0000, 3'b110));
    tbl.push_back(mk(4'd1, 16'hFFFF, 16'h0, 16'h0, 0, 0, 1, 16'h0000, 16'hFFFF, 3'b101));
    tbl.push_back(mk(4'd6, 16'hF0F0, 16'hFFFF, 16'h0F0F, 1, 1, 1, 16'h0000, 16'hFFFF, 3'b101));
    tbl.push_back(mk(4'd7, 16'h8000, 16'h0001, 16'h0, 0, 0, 1, 16'h8001, 16'h8000, 3'b110));
    tbl.push_back(mk(4'd8, 16'h4001, 16'h0001, 16'h0, 0, 0, 1, 16'h8002, 16'h4001, 3'b010));
    tbl.push_back(mk(4'd9, 16'h0003, 16'h0001, 16'h0, 0, 0, 1, 16'h0001, 16'h0003, 3'b100));
    tbl.push_back(mk(4'd9, 16'h0000, 16'h0010, 16'h0, 0, 0, 1, 16'h0000, 16'h0000, 3'b101));
    tbl.push_back(mk(4'd8, 16'h8000, 16'h0000, 16'h0, 0, 0, 1, 16'h8000, 16'h8000, 3'b110));
    v = mk(4'd12, 16'h2222, 16'h9999, 16'h0, 0, 1, 1, 16'h0000, 16'h0000, 3'b101);
    v.rs2 = 3'd5; v.wb_en = 1; v.wb_rd = 3'd5; v.wb_data = 16'h0000;
    v.mem_en = 1; v.mem_rd = 3'd4; v.mem_data = 16'h1111;
    tbl.push_back(v);
    tbl.push_back(mk(4'd13, 16'h1357, 16'h0, 16'h0, 0, 0, 1, 16'h1357, 16'h1357, 3'b101));
    tbl.push_back(mk(4'd5, 16'h0005, 16'h0000, 16'h0005, 1, 0, 1, 16'h0000, 16'h0005, 3'b001));
    v = mk(4'd4, 16'hDEAD, 16'hDEAD, 16'h0, 0, 0, 1, 16'h0123, 16'h0023, 3'b000);
    v.rs1 = 3'd1; v.rs2 = 3'd2; v.mem_en = 1; v.mem_rd = 3'd2; v.mem_data = 16'h0100;
    v.wb_en = 1; v.wb_rd = 3'd1; v.wb_data = 16'h0023;
    tbl.push_back(v);
    // Save / SETC / restore, including restore overriding ALU flags and save+restore together
    tbl.push_back(mk(4'd2, 16'h7FFF, 16'h0, 16'h0, 0, 0, 1, 16'h8000, 16'h7FFF, 3'b010));
    v = mk(4'd0, 16'h0042, 16'h0, 16'h0, 0, 0, 0, 16'h0042, 16'h0042, 3'b010); v.save = 1;
    tbl.push_back(v);
    v = mk(4'd10, 16'h0042, 16'h0, 16'h0, 0, 0, 1, 16'h0, 16'h0042, 3'b110); v.cr = 0;
    tbl.push_back(v);
    v = mk(4'd4, 16'hFFFF, 16'h0001, 16'h0, 0, 0, 1, 16'h0000, 16'hFFFF, 3'b010); v.rest = 1;
    tbl.push_back(v);
    tbl.push_back(mk(4'd4, 16'hFFFF, 16'h0001, 16'h0, 0, 0, 1, 16'h0000, 16'hFFFF, 3'b101));
    v = mk(4'd11, 16'h0000, 16'h0, 16'h0, 0, 0, 1, 16'h0, 16'h0000, 3'b001); v.cr = 0;
    tbl.push_back(v);
    v = mk(4'd0, 16'h0007, 16'h0, 16'h0, 0, 0, 0, 16'h0007, 16'h0007, 3'b010);
    v.save = 1; v.rest = 1;
    tbl.push_back(v);
    tbl.push_back(mk(4'd4, 16'hFFFF, 16'h0001, 16'h0, 0, 0, 1, 16'h0000, 16'hFFFF, 3'b101));
    v = mk(4'd0, 16'h0000, 16'h0, 16'h0, 0, 0, 0, 16'h0000, 16'h0000, 3'b010); v.rest = 1;
    tbl.push_back(v);
    tbl.push_back(mk(4'd4, 16'hFFFF, 16'h0001, 16'h0, 0, 0, 1, 16'h0000, 16'hFFFF, 3'b101));

    @(negedge clk); #1;
    check_all_zero("reset");
    @(posedge clk);
    rst = 1'b1; enable = 1'b1;

    foreach (tbl[i]) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
      $display("vec%0d op=%0d res=%h flags=%b store=%h", i, tbl[i].op, o_alu_result, o_flags, o_store_data);
    end

    // Stall: inputs keep changing (incl. restore/flag change) but nothing may move
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      enable = 1'b0;
      v = mk(4'd4, 16'(c + 1), 16'h0001, 16'h0, 0, 0, 1, 16'h0, 16'h0, 3'b0);
      v.rest = 1;
      drive(v, fe);
      @(negedge clk); #1;
      check_out($sformatf("stall%0d", c), last_e);
      $display("stall%0d res=%h flags=%b", c, o_alu_result, o_flags);
    end

    // Flush: control cleared, flag update and restore ignored
    @(posedge clk);
    enable = 1'b1; flush = 1'b1;
    v = mk(4'd4, 16'h0001, 16'h0001, 16'h0, 0, 0, 1, 16'h0002, 16'h0001, 3'b101);
    v.rest = 1;
    drive(v, fe);
    i_WB = '1; i_Mem = '1; i_output_write = 1'b1;
    fe.wb = '0; fe.mem = '0; fe.ow = 1'b0;
    sb.push_back(fe);
    pop_check("flush");
    $display("flush WB=%h Mem=%h ow=%b flags=%b", o_WB, o_Mem, o_output_write, o_flags);
    flush = 1'b0;

    // Asynchronous reset between edges, checked before the next negedge
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_all_zero("async_reset");
    $display("async_reset res=%h flags=%b pc=%h", o_alu_result, o_flags, o_pc);
    @(posedge clk);
    rst = 1'b1;
    v = mk(4'd0, 16'h00AA, 16'h0, 16'h0, 0, 0, 0, 16'h00AA, 16'h00AA, 3'b000); v.rest = 1;
    run_vec(v, "post_reset_restore");
    $display("post_reset_restore res=%h flags=%b", o_alu_result, o_flags);
    run_vec(mk(4'd4, 16'h0002, 16'h0003, 16'h0, 0, 0, 1, 16'h0005, 16'h0002, 3'b000), "post_reset_add");
    $display("post_reset_add res=%h flags=%b", o_alu_result, o_flags);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_stage.md
ALU_STAGE -- requirements
Module: alu_stage

Interface
REQ-001 SHALL have parameter WbSize, default 2, meaning width of write-back control bundle.
REQ-002 SHALL have parameter MemSize, default 9, meaning width of memory control bundle.
REQ-003 SHALL have parameter ExSize, default 14, meaning width of execute control bundle.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on negedge clk.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1, high = advance; low = hold all state (stall).
REQ-007 SHALL have port flush, input, 1, high = load a bubble instead of the current instruction.
REQ-008 SHALL have ports i_WB/i_Mem/i_pc/i_Rdst/i_output_write, inputs, WbSize/MemSize/32/3/1, pass-through control and data from decode/ALU buffer.
REQ-009 SHALL have ports i_Ex, i_chg_flag, inputs, ExSize/1; i_Ex[3:0] = alu_op, i_Ex[4] = op2 select immediate, i_Ex[5] = store-data select forwarded op2.
REQ-010 SHALL have ports i_Rsrc1, i_Rsrc2, inputs, 3 each, source register indices.
REQ-011 SHALL have ports i_read_data1, i_read_data2, i_immd, inputs, 16 each, register-file operands and immediate.
REQ-012 SHALL have ports i_fw_mem_en, i_fw_mem_rd, i_fw_mem_data, inputs, 1/3/16, forwarding source from ALU/memory buffer.
REQ-013 SHALL have ports i_fw_wb_en, i_fw_wb_rd, i_fw_wb_data, inputs, 1/3/16, forwarding source from memory/write-back buffer.
REQ-014 SHALL have ports i_flag_save, i_flag_restore, inputs, 1 each, interrupt-entry save / RTI restore of flags.
REQ-015 SHALL have ports o_WB/o_Mem/o_pc/o_Rdst/o_output_write, outputs, registered copies of REQ-008 inputs.
REQ-016 SHALL have ports o_alu_result, o_store_data, outputs, 16 each, registered result and memory store data.
REQ-017 SHALL have port o_flags, output, 3, live CCR {C,N,Z} for branch resolution.

Function
REQ-018 SHALL forward op1: if i_fw_mem_en and i_fw_mem_rd==i_Rsrc1 use i_fw_mem_data, else if i_fw_wb_en and i_fw_wb_rd==i_Rsrc1 use i_fw_wb_data, else i_read_data1; op2 source identical with i_Rsrc2 (memory buffer wins when both match).
REQ-019 SHALL use op2 = i_immd when i_Ex[4]=1, else forwarded op2; o_store_data = forwarded op2 when i_Ex[5]=1, else forwarded op1.
REQ-020 SHALL implement alu_op: 0 pass op1, 1 NOT, 2 INC, 3 DEC, 4 ADD, 5 SUB (op1-op2), 6 AND, 7 OR, 8 SHL op1 by op2[3:0], 9 SHR logical by op2[3:0], 10 SETC, 11 CLRC, 12 pass op2, 13-15 pass op1.
REQ-021 SHALL compute arithmetic in 17 bits; C = bit16 for ADD/INC, borrow (op1<op2) for SUB, borrow (op1==0) for DEC; SHL C = last bit shifted out, shift by 0 leaves C unchanged; SHR C = last bit shifted out, shift by 0 leaves C unchanged.
REQ-022 SHALL update Z = (result==0) and N = result[15] for ops 1-9 and 12; SETC/CLRC change only C; ops 0, 13-15 change no flag.
REQ-023 SHALL write CCR on negedge clk only when enable=1, flush=0 and i_chg_flag=1.
REQ-024 SHALL on i_flag_save (enable=1) copy the current CCR into a saved-flags register; on i_flag_restore load CCR from saved-flags, overriding any same-cycle ALU flag update; save and restore together = restore wins, saved register unchanged.
REQ-025 SHALL register all outputs with latency of one negedge; enable=0 holds outputs, CCR and saved flags.
REQ-026 SHALL on flush=1 with enable=1 load o_WB=0, o_Mem=0, o_output_write=0, keep CCR and saved flags, and ignore i_flag_save/i_flag_restore; flush with enable=0 has no effect.

Reset
REQ-027 SHALL on rst=0, immediately and independent of clk, clear every output, CCR and saved-flags register to 0.
REQ-028 SHALL resume normal operation at the first negedge clk after rst returns to 1; reset mid-stall or mid-flush discards pending state.

Structure
REQ-029 SHALL take alu_op encodings, control-bit indices of i_Ex and CCR bit positions from a shared package alu_pkg.
REQ-030 SHALL instantiate one combinational sub-module alu_core (op1, op2, alu_op, carry-in -> result, flags); forwarding, CCR and output registers stay in alu_stage.

Verification
REQ-031 SHALL test ADD 0xFFFF+0x0001, i_chg_flag=1 -> o_alu_result=0x0000, o_flags {C,N,Z}=3'b101 after one negedge.
REQ-032 SHALL test dual-forward conflict: i_Rsrc1=3, mem rd=3 data 0x1234, wb rd=3 data 0x5678, alu_op=0 -> o_alu_result=0x1234.
REQ-033 SHALL test SUB 0x0003-0x0005 with i_chg_flag=0 -> o_alu_result=0xFFFE, o_flags unchanged.
REQ-034 SHALL test enable=0 for 3 cycles with changing inputs -> outputs and o_flags frozen; flush=1, enable=1 -> o_WB=0, o_Mem=0, o_output_write=0.
REQ-035 SHALL test save with flags 3'b011, then SETC, then restore -> o_flags=3'b111 after SETC, 3'b011 after restore.
REQ-036 SHALL test rst=0 asserted between clock edges -> all outputs 0 immediately, before the next negedge.
